rnn_mem_arbiter: RTL
====================

# rnn_mem_arbiter

Two-requester arbiter and sequencer for the single RNN memory port (`mce`/`maddr`/`msel`/`mdata_w`/`mdata_r`). It sits between the memory and two masters: requester 0 is the RNN compute core (weight/bias fetch, h write-back), and requester 1 is the host loader/readback path. It provides round-robin ownership with burst hold, a starvation cap, and routes read data back to the issuing requester.

## Interface
Parameters:
- `ADDR_W`, default 17: memory address width.
- `DATA_W`, default 20: memory data width.
- `MAX_BURST`, default 64: maximum beats per ownership period while the other requester is waiting.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req[1:0]` in 2: requester wants or holds the bus.
- `gnt[1:0]` out 2: one-hot or zero; requester owns the bus.
- `vld[1:0]` in 2: requester issues a beat this cycle. Ignored unless the matching `gnt` is high.
- `sel0`, `sel1` in 3 each: memory select per requester. `3'b101` is a write; all other codes are reads.
- `addr0`, `addr1` in ADDR_W each: beat address.
- `wdata0`, `wdata1` in DATA_W each: write data.
- `rvalid[1:0]` out 2: read data valid for that requester.
- `rdata` out DATA_W: registered copy of `mdata_r`, shared by both requesters.
- `mce` out 1, `maddr` out 17, `msel` out 3, `mdata_w` out 20: memory port.
- `mdata_r` in 20: memory read data, valid 1 cycle after the address.

## Operation
- States:
  - IDLE: no owner; `gnt`=0.
  - OWN0 / OWN1: one owner.
  - TURN: one dead cycle on any ownership change.
- IDLE transitions:
  - Only one `req` high: go to the matching OWN state.
  - Both high: choose by the round-robin pointer `last`, which favours the requester not served last. After reset, `last`=1, so requester 0 wins the first tie.
- OWNi behaviour:
  - `gnt[i]`=1.
  - Each cycle with `vld[i]` is one beat. A registered beat drives `mce`=1, `maddr`=`addri`, `msel`=`seli`, and `mdata_w`=`wdatai` on writes. On reads `mdata_w` holds its previous value.
  - The beat counter increments on each beat.
- Leaving OWNi:
  - If `req[i]` falls: go to TURN, or to IDLE if the other `req` is low.
  - If the beat counter reaches MAX_BURST while the other `req` is high: go to TURN (forced release).
  - If the other requester is idle, the beat cap does not apply and the counter saturates.
- TURN: `gnt`=0 and no beat issues. The next cycle enters the OWN state of the other requester. If the other `req` has dropped, go to IDLE instead. `last` updates on entry to OWN.
- Read return: a 2-stage shift register of {valid, owner} per beat. `rvalid[owner]` and `rdata` assert 2 cycles after the `vld` beat. Read returns are never dropped across TURN or ownership changes.
- `gnt` falls in the same cycle as the state exit. A `vld` sampled on that edge is still accepted, because it was sampled while `gnt` was high.
- When no beat is issued, `mce`=0, `msel`=`3'b100` (idle code), and `maddr` holds its previous value.

## Timing
- Reset values: `gnt`=0, `rvalid`=0, `rdata`=0, `mce`=0, `maddr`=0, `msel`=`3'b100`, `mdata_w`=0, state IDLE, `last`=1, beat counter 0, return pipe cleared.
- Reset mid-burst takes effect on the next edge. In-flight read returns are discarded.
- Grant latency from IDLE: `req` sampled high at edge N gives `gnt` high after edge N.
- Beat to memory: `vld` at edge N drives the memory outputs after edge N. Memory data arrives at edge N+1. `rvalid`/`rdata` are visible after edge N+2.
- Throughput: 1 beat per cycle within ownership. Each handover costs exactly 1 idle cycle.
- `req` both high at IDLE with the same edge as reset release: reset wins. Arbitration starts on the following edge.

## Structure
- Shared package `rnn_pkg` holds:
  - `MSEL_IDLE`=3'b100, `MSEL_HW`=3'b001, `MSEL_WX_BIAS`=3'b011, `MSEL_WX`=3'b000, `MSEL_OUT`=3'b101, `MSEL_WH`=3'b010.
  - The state enum {IDLE, OWN0, OWN1, TURN}.
  - `DATA_W`/`ADDR_W` defaults.
- Sub-module `rnn_rd_return`: the 2-stage {valid, owner} shift register plus the `rdata` register. Everything else stays flat.

## Test plan
- Single requester 0: `req0`=1, 4 read beats at addresses 0..3 with `msel`=001. Expect `gnt0` one edge later, `mce` high for 4 cycles, and `rvalid[0]` for 4 cycles starting 2 cycles after the first beat with matching `mdata_r` values.
- Tie after reset: `req`=2'b11 → `gnt`=01 first. Drop `req0` → one TURN cycle with `mce`=0, then `gnt`=10.
- Starvation cap, MAX_BURST=4: requester 0 streams continuously while `req1`=1. Expect exactly 4 beats, TURN, then `gnt`=10, then requester 0 again after requester 1 releases.
- Write path: requester 1 issues sel=101, addr=0x00040, wdata=0x0FFFF. Expect `msel`=101, `maddr`=0x00040, `mdata_w`=0x0FFFF, `mce`=1, and no `rvalid`.
- Read in flight across a handover: requester 0's last read beat is followed by TURN. Expect `rvalid[0]` still delivered during TURN/OWN1 and never `rvalid[1]` for it.
- Reset mid-burst after 2 read beats: expect all outputs at reset values on the next cycle and no `rvalid` pulses for the flushed reads.

Source files
------------

// File: rtl/rnn_pkg.sv
// Shared definitions for the RNN memory-port arbiter: select codes, state encoding
// and default bus widths.
package rnn_pkg;

  localparam int unsigned RNN_ADDR_W = 17;
  localparam int unsigned RNN_DATA_W = 20;

  localparam logic [2:0] MSEL_IDLE    = 3'b100;
  localparam logic [2:0] MSEL_HW      = 3'b001;
  localparam logic [2:0] MSEL_WX_BIAS = 3'b011;
  localparam logic [2:0] MSEL_WX      = 3'b000;
  localparam logic [2:0] MSEL_OUT     = 3'b101;
  localparam logic [2:0] MSEL_WH      = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2,
    TURN = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic valid;
    logic owner;
  } rd_tag_t;

endpackage

// File: rtl/rnn_rd_return.sv
// Read-return path: tags each read beat with its owner and delivers the registered
// memory data to that requester two cycles after the beat.
module rnn_rd_return
  import rnn_pkg::*;
#(
  parameter int unsigned DATA_W = RNN_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic              issue_owner,
  input  logic [DATA_W-1:0] mdata_r,
  output logic [1:0]        rvalid,
  output logic [DATA_W-1:0] rdata
);

  rd_tag_t           s1_q, s1_d;
  rd_tag_t           s2_q, s2_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Stage 2 lines up with the cycle in which the memory presents the read data.
  always_comb begin
    s1_d     = '{valid: issue_valid, owner: issue_owner};
    s2_d     = s1_q;
    rvalid_d = '0;
    rdata_d  = rdata_q;
    if (s2_q.valid) begin
      rvalid_d[s2_q.owner] = 1'b1;
      rdata_d              = mdata_r;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;

endmodule

// File: rtl/rnn_mem_arbiter.sv
// Round-robin arbiter for the single RNN memory port, shared by the compute core
// (requester 0) and the host loader (requester 1), with burst hold and starvation cap.
module rnn_mem_arbiter
  import rnn_pkg::*;
#(
  parameter int unsigned ADDR_W    = RNN_ADDR_W,
  parameter int unsigned DATA_W    = RNN_DATA_W,
  parameter int unsigned MAX_BURST = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  output logic [1:0]        gnt,
  input  logic [1:0]        vld,
  input  logic [2:0]        sel0,
  input  logic [2:0]        sel1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mce,
  output logic [ADDR_W-1:0] maddr,
  output logic [2:0]        msel,
  output logic [DATA_W-1:0] mdata_w,
  input  logic [DATA_W-1:0] mdata_r
);

  localparam int unsigned    CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  arb_state_e        state_q, state_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mce_q, mce_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [2:0]        msel_q, msel_d;
  logic [DATA_W-1:0] mdata_w_q, mdata_w_d;

  logic              owning;
  logic              owner;
  logic              beat;
  logic              is_wr;
  logic              other_req;
  logic              pick;
  logic [2:0]        b_sel;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic [CNT_W-1:0]  cnt_inc;

  always_comb begin
    owning    = (state_q == OWN0) || (state_q == OWN1);
    owner     = (state_q == OWN1);
    beat      = owning && vld[owner];
    b_sel     = owner ? sel1   : sel0;
    b_addr    = owner ? addr1  : addr0;
    b_wdata   = owner ? wdata1 : wdata0;
    is_wr     = (b_sel == MSEL_OUT);
    other_req = req[!owner];
    // Saturates so an uncontested owner can stream indefinitely, yet is released
    // at the next beat once the other side starts asking.
    cnt_inc   = (beat && (cnt_q != CNT_MAX)) ? cnt_q + CNT_W'(1) : cnt_q;
    pick      = (req == 2'b11) ? !last_q : req[1];
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req != 2'b00) begin
          state_d = pick ? OWN1 : OWN0;
          last_d  = pick;
        end
      end
      OWN0, OWN1: begin
        cnt_d = cnt_inc;
        if (!req[owner]) begin
          state_d = other_req ? TURN : IDLE;
          cnt_d   = '0;
        end else if (other_req && (cnt_inc == CNT_MAX)) begin
          state_d = TURN;
          cnt_d   = '0;
        end
      end
      TURN: begin
        // last_q still names the owner that just left; hand over to the other one.
        cnt_d = '0;
        if (req[!last_q]) begin
          state_d = last_q ? OWN0 : OWN1;
          last_d  = !last_q;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mce_d     = beat;
    maddr_d   = beat ? b_addr : maddr_q;
    msel_d    = beat ? b_sel  : MSEL_IDLE;
    mdata_w_d = (beat && is_wr) ? b_wdata : mdata_w_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      mce_q     <= 1'b0;
      maddr_q   <= '0;
      msel_q    <= MSEL_IDLE;
      mdata_w_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      mce_q     <= mce_d;
      maddr_q   <= maddr_d;
      msel_q    <= msel_d;
      mdata_w_q <= mdata_w_d;
    end
  end

  rnn_rd_return #(
    .DATA_W(DATA_W)
  ) u_rd_return (
    .clk        (clk),
    .reset      (reset),
    .issue_valid(beat && !is_wr),
    .issue_owner(owner),
    .mdata_r    (mdata_r),
    .rvalid     (rvalid),
    .rdata      (rdata)
  );

  assign gnt     = {state_q == OWN1, state_q == OWN0};
  assign mce     = mce_q;
  assign maddr   = maddr_q;
  assign msel    = msel_q;
  assign mdata_w = mdata_w_q;

endmodule
